// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake for the decode stage: byte stream in, decoded bundle out.
// slave is the decode stage's view; master is the fetch/execute environment's view.
interface decode_stage_if #(
   parameter int DW  = 8,
   parameter int RW  = 3,
   parameter int OPW = 8,
   parameter int AMW = 4
);
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  in_data;
   logic           c_da;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [OPW-1:0] out_opcode;
   logic [RW-1:0]  out_op1;
   logic [RW-1:0]  out_op2;
   logic [RW-1:0]  out_iaddr;
   logic [RW-1:0]  out_oaddr;
   logic [AMW-1:0] out_alu_mode;
   logic [DW-1:0]  out_imm;
   logic           out_has_imm;
   logic           out_illegal;

   modport slave (
      input  in_valid, in_data, c_da, flush, out_ready,
      output in_ready, out_valid, out_opcode, out_op1, out_op2, out_iaddr,
             out_oaddr, out_alu_mode, out_imm, out_has_imm, out_illegal
   );

   modport master (
      output in_valid, in_data, c_da, flush, out_ready,
      input  in_ready, out_valid, out_opcode, out_op1, out_op2, out_iaddr,
             out_oaddr, out_alu_mode, out_imm, out_has_imm, out_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: turns one- or two-byte instructions into a registered
// bundle with a valid/ready handshake toward execute.
//
//   state  | meaning
//   S_OP   | waiting for an opcode byte
//   S_IMM  | opcode latched in pending register, waiting for its immediate byte
//   S_HALT | HLT decoded; no bytes accepted until flush
//
// Opcode byte encodings (8-bit code, d = operand1 field, s = operand2 field):
//   01dd_dsss MOV   1000_mmmm ALU   1001_0sss CMP   1010_0sss ROUT
//   0000_0sss LDI*  0000_1sss LDA*  0001_0sss STA*  0001_1sss LDX
//   0010_0sss STX   0010_1sss PUSH  0011_0sss POP   0011_1sss RIN
//   1100_0000 JMP*  1100_0001 CALL* 1100_0010 RET   1100_0011 NOP
//   1100_0100 HLT   (* = followed by an immediate byte; anything else is illegal)
module decode_stage #(
   parameter int DW  = 8,
   parameter int RW  = 3,
   parameter int OPW = 8,
   parameter int AMW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   decode_stage_if.slave  bus
);

   localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
   localparam logic [OPW-1:0] OP_MOV  = OPW'(1);
   localparam logic [OPW-1:0] OP_ALU  = OPW'(2);
   localparam logic [OPW-1:0] OP_CMP  = OPW'(3);
   localparam logic [OPW-1:0] OP_LDI  = OPW'(4);
   localparam logic [OPW-1:0] OP_LDA  = OPW'(5);
   localparam logic [OPW-1:0] OP_STA  = OPW'(6);
   localparam logic [OPW-1:0] OP_LDX  = OPW'(7);
   localparam logic [OPW-1:0] OP_STX  = OPW'(8);
   localparam logic [OPW-1:0] OP_PUSH = OPW'(9);
   localparam logic [OPW-1:0] OP_POP  = OPW'(10);
   localparam logic [OPW-1:0] OP_RIN  = OPW'(11);
   localparam logic [OPW-1:0] OP_ROUT = OPW'(12);
   localparam logic [OPW-1:0] OP_JMP  = OPW'(13);
   localparam logic [OPW-1:0] OP_CALL = OPW'(14);
   localparam logic [OPW-1:0] OP_RET  = OPW'(15);
   localparam logic [OPW-1:0] OP_HLT  = OPW'(16);

   localparam logic [7:0] PATTERN_MOV  = 8'b01??_????;
   localparam logic [7:0] PATTERN_ALU  = 8'b1000_????;
   localparam logic [7:0] PATTERN_CMP  = 8'b1001_0???;
   localparam logic [7:0] PATTERN_ROUT = 8'b1010_0???;
   localparam logic [7:0] PATTERN_LDI  = 8'b0000_0???;
   localparam logic [7:0] PATTERN_LDA  = 8'b0000_1???;
   localparam logic [7:0] PATTERN_STA  = 8'b0001_0???;
   localparam logic [7:0] PATTERN_LDX  = 8'b0001_1???;
   localparam logic [7:0] PATTERN_STX  = 8'b0010_0???;
   localparam logic [7:0] PATTERN_PUSH = 8'b0010_1???;
   localparam logic [7:0] PATTERN_POP  = 8'b0011_0???;
   localparam logic [7:0] PATTERN_RIN  = 8'b0011_1???;
   localparam logic [7:0] PATTERN_JMP  = 8'b1100_0000;
   localparam logic [7:0] PATTERN_CALL = 8'b1100_0001;
   localparam logic [7:0] PATTERN_RET  = 8'b1100_0010;
   localparam logic [7:0] PATTERN_NOP  = 8'b1100_0011;
   localparam logic [7:0] PATTERN_HLT  = 8'b1100_0100;

   localparam logic [RW-1:0]  REG_A   = '1;
   localparam logic [RW-1:0]  REG_H   = RW'((1 << RW) - 2);
   localparam logic [AMW-1:0] ALU_SUB = AMW'(1);

   typedef enum logic [1:0] {
      S_OP   = 2'd0,
      S_IMM  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   // has_imm doubles as "needs an immediate byte" in the decoder output
   typedef struct packed {
      logic [OPW-1:0] opcode;
      logic [RW-1:0]  op1;
      logic [RW-1:0]  op2;
      logic [RW-1:0]  iaddr;
      logic [RW-1:0]  oaddr;
      logic [AMW-1:0] alu_mode;
      logic [DW-1:0]  imm;
      logic           has_imm;
      logic           illegal;
   } bundle_t;

   state_t  state_q, state_d;
   bundle_t out_q, out_d;
   bundle_t pend_q, pend_d;
   bundle_t dec;
   logic    out_valid_q, out_valid_d;
   logic    in_ready;
   logic    accept;
   logic [7:0] code;

   assign code     = 8'(bus.in_data);
   assign in_ready = (!out_valid_q || bus.out_ready) && (state_q != S_HALT) && !bus.flush;
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      dec          = '0;
      dec.opcode   = OP_NOP;
      dec.op1      = bus.in_data[2*RW-1:RW];
      dec.op2      = bus.in_data[RW-1:0];
      casez (code)
         PATTERN_MOV: begin
            dec.opcode = OP_MOV;
            dec.iaddr  = dec.op1;
            dec.oaddr  = dec.op2;
         end
         PATTERN_ALU: begin
            dec.opcode   = OP_ALU;
            dec.iaddr    = REG_A;
            dec.alu_mode = bus.in_data[AMW-1:0];
         end
         PATTERN_CMP: begin
            dec.opcode   = OP_CMP;
            dec.alu_mode = ALU_SUB;
         end
         PATTERN_ROUT: begin
            dec.opcode = OP_ROUT;
            dec.oaddr  = dec.op2;
         end
         PATTERN_LDI: begin
            dec.opcode  = OP_LDI;
            dec.iaddr   = dec.op2;
            dec.has_imm = 1'b1;
         end
         PATTERN_LDA: begin
            dec.opcode  = OP_LDA;
            dec.iaddr   = dec.op2;
            dec.oaddr   = REG_A;
            dec.has_imm = 1'b1;
         end
         PATTERN_STA: begin
            // c_da is captured here, with the opcode byte, not with the immediate
            dec.opcode  = OP_STA;
            dec.oaddr   = bus.c_da ? REG_A : dec.op2;
            dec.has_imm = 1'b1;
         end
         PATTERN_LDX: begin
            dec.opcode = OP_LDX;
            dec.iaddr  = dec.op2;
         end
         PATTERN_STX: begin
            dec.opcode = OP_STX;
            dec.oaddr  = dec.op2;
         end
         PATTERN_PUSH: begin
            dec.opcode = OP_PUSH;
            dec.oaddr  = dec.op2;
         end
         PATTERN_POP: begin
            dec.opcode = OP_POP;
            dec.iaddr  = dec.op2;
         end
         PATTERN_RIN: begin
            dec.opcode = OP_RIN;
            dec.iaddr  = dec.op2;
         end
         PATTERN_JMP: begin
            dec.opcode  = OP_JMP;
            dec.has_imm = 1'b1;
         end
         PATTERN_CALL: begin
            dec.opcode  = OP_CALL;
            dec.iaddr   = REG_H;
            dec.oaddr   = REG_H;
            dec.has_imm = 1'b1;
         end
         PATTERN_RET:  dec.opcode = OP_RET;
         PATTERN_NOP:  dec.opcode = OP_NOP;
         PATTERN_HLT:  dec.opcode = OP_HLT;
         default:      dec.illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      pend_d      = pend_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      if (bus.flush) begin
         state_d     = S_OP;
         out_valid_d = 1'b0;
         pend_d      = '0;
      end else if (accept) begin
         unique case (state_q)
            S_OP: begin
               if (dec.has_imm) begin
                  pend_d  = dec;
                  state_d = S_IMM;
               end else begin
                  out_d       = dec;
                  out_valid_d = 1'b1;
                  if (dec.opcode == OP_HLT) state_d = S_HALT;
               end
            end
            S_IMM: begin
               out_d         = pend_q;
               out_d.imm     = bus.in_data;
               out_d.has_imm = 1'b1;
               out_valid_d   = 1'b1;
               pend_d        = '0;
               state_d       = S_OP;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_OP;
         out_q       <= '0;
         pend_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_opcode   = out_q.opcode;
   assign bus.out_op1      = out_q.op1;
   assign bus.out_op2      = out_q.op2;
   assign bus.out_iaddr    = out_q.iaddr;
   assign bus.out_oaddr    = out_q.oaddr;
   assign bus.out_alu_mode = out_q.alu_mode;
   assign bus.out_imm      = out_q.imm;
   assign bus.out_has_imm  = out_q.has_imm;
   assign bus.out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded instruction bytes, expected bundles
// written out as constants from the encoding table in the design header.
module tb_decode_stage;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   decode_stage_if #(.DW(8), .RW(3), .OPW(8), .AMW(4)) bus ();

   decode_stage #(.DW(8), .RW(3), .OPW(8), .AMW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic cda,
                        input logic fl, input logic ordy);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.c_da      = cda;
      bus.flush     = fl;
      bus.out_ready = ordy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bundle(input string tag, input logic [7:0] opc, input logic [2:0] ia,
                               input logic [2:0] oa, input logic [3:0] mode, input logic [7:0] imm,
                               input logic has_imm, input logic ill);
      check({tag, ".valid"},    32'(bus.out_valid),    32'd1);
      check({tag, ".opcode"},   32'(bus.out_opcode),   32'(opc));
      check({tag, ".iaddr"},    32'(bus.out_iaddr),    32'(ia));
      check({tag, ".oaddr"},    32'(bus.out_oaddr),    32'(oa));
      check({tag, ".alu_mode"}, 32'(bus.out_alu_mode), 32'(mode));
      check({tag, ".imm"},      32'(bus.out_imm),      32'(imm));
      check({tag, ".has_imm"},  32'(bus.out_has_imm),  32'(has_imm));
      check({tag, ".illegal"},  32'(bus.out_illegal),  32'(ill));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.c_da      = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      // reset acts before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("rst.valid",   32'(bus.out_valid),   32'd0);
      check("rst.opcode",  32'(bus.out_opcode),  32'd0);
      check("rst.imm",     32'(bus.out_imm),     32'd0);
      check("rst.has_imm", 32'(bus.out_has_imm), 32'd0);
      check("rst.iaddr",   32'(bus.out_iaddr),   32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("rst.in_ready", 32'(bus.in_ready), 32'd1);

      // MOV r2 <- r5 : 01_010_101
      drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      check("mov.in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check_bundle("mov", 8'd1, 3'd2, 3'd5, 4'd0, 8'h00, 1'b0, 1'b0);
      check("mov.op1", 32'(bus.out_op1), 32'd2);
      check("mov.op2", 32'(bus.out_op2), 32'd5);

      // LDI r3, 0xA5
      drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
      tick();
      check("ldi.no_early_bundle", 32'(bus.out_valid), 32'd0);
      drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      tick();
      check_bundle("ldi", 8'd4, 3'd3, 3'd0, 4'd0, 8'hA5, 1'b1, 1'b0);

      // STA: c_da=1 with opcode, 0 with immediate -> oaddr REG_A (7)
      drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b1);
      tick();
      check("sta.no_early_bundle", 32'(bus.out_valid), 32'd0);
      drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      tick();
      check_bundle("sta", 8'd6, 3'd0, 3'd7, 4'd0, 8'h3C, 1'b1, 1'b0);

      // three ALU bytes against a stalled execute stage
      drive(1'b1, 8'h81, 1'b0, 1'b0, 1'b1);
      tick();
      check_bundle("alu1", 8'd2, 3'd7, 3'd0, 4'd1, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
      check("stall.in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check_bundle("alu1_hold_a", 8'd2, 3'd7, 3'd0, 4'd1, 8'h00, 1'b0, 1'b0);
      tick();
      check_bundle("alu1_hold_b", 8'd2, 3'd7, 3'd0, 4'd1, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 8'h82, 1'b0, 1'b0, 1'b1);
      check("unstall.in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check_bundle("alu2", 8'd2, 3'd7, 3'd0, 4'd2, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 8'h83, 1'b0, 1'b0, 1'b1);
      tick();
      check_bundle("alu3", 8'd2, 3'd7, 3'd0, 4'd3, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      check("drain.valid", 32'(bus.out_valid), 32'd0);

      // flush while waiting for LDA's immediate
      drive(1'b1, 8'h0A, 1'b0, 1'b0, 1'b1);
      tick();
      check("lda.no_early_bundle", 32'(bus.out_valid), 32'd0);
      drive(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
      check("flush.in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("flush.valid", 32'(bus.out_valid), 32'd0);
      drive(1'b1, 8'h85, 1'b0, 1'b0, 1'b1);
      tick();
      check_bundle("post_flush_alu", 8'd2, 3'd7, 3'd0, 4'd5, 8'h00, 1'b0, 1'b0);

      // HLT, then bytes that must be refused
      drive(1'b1, 8'hC4, 1'b0, 1'b0, 1'b1);
      tick();
      check_bundle("hlt", 8'd16, 3'd0, 3'd0, 4'd0, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      check("halt.in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("halt.valid_a", 32'(bus.out_valid), 32'd0);
      tick();
      check("halt.valid_b", 32'(bus.out_valid), 32'd0);
      check("halt.in_ready_b", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
      tick();
      check("halt_flush.valid", 32'(bus.out_valid), 32'd0);
      drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      check("resume.in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check_bundle("resume_mov", 8'd1, 3'd2, 3'd5, 4'd0, 8'h00, 1'b0, 1'b0);

      // unmatched byte
      drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
      tick();
      check_bundle("illegal", 8'd0, 3'd0, 3'd0, 4'd0, 8'h00, 1'b0, 1'b1);

      // CMP r2 -> ALU_SUB
      drive(1'b1, 8'h92, 1'b0, 1'b0, 1'b1);
      tick();
      check_bundle("cmp", 8'd3, 3'd0, 3'd0, 4'd1, 8'h00, 1'b0, 1'b0);

      // CALL 0x77 -> REG_H (6) on both ports
      drive(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1);
      tick();
      check("call.no_early_bundle", 32'(bus.out_valid), 32'd0);
      drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
      tick();
      check_bundle("call", 8'd14, 3'd6, 3'd6, 4'd0, 8'h77, 1'b1, 1'b0);

      // PUSH r4 / POP r1
      drive(1'b1, 8'h2C, 1'b0, 1'b0, 1'b1);
      tick();
      check_bundle("push", 8'd9, 3'd0, 3'd4, 4'd0, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 8'h31, 1'b0, 1'b0, 1'b1);
      tick();
      check_bundle("pop", 8'd10, 3'd1, 3'd0, 4'd0, 8'h00, 1'b0, 1'b0);

      // reset in S_IMM drops the pending LDI
      drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_imm.valid", 32'(bus.out_valid), 32'd0);
      check("rst_imm.opcode", 32'(bus.out_opcode), 32'd0);
      tick();
      rst_n = 1'b1;
      drive(1'b1, 8'h86, 1'b0, 1'b0, 1'b1);
      tick();
      check_bundle("rst_imm_alu", 8'd2, 3'd7, 3'd0, 4'd6, 8'h00, 1'b0, 1'b0);

      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
